// File: rtl/uart_rx_line_buffer.sv
// Line buffer behind the uart receiver: collects bytes up to a terminator and
// hands the finished line to the TX side through a first-word-fall-through read port.
module uart_rx_line_buffer #(
    parameter int         DEPTH         = 16,
    parameter logic [7:0] TERMINATOR    = 8'h0D,
    parameter bit         DROP_ON_ERROR = 1'b1,
    parameter int         LW            = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          received,
    input  logic [7:0]    rx_byte,
    input  logic          recv_error,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          line_valid,
    output logic [LW-1:0] line_len,
    output logic          overflow
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_COLLECT, S_DISCARD, S_READY} state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [LW-1:0] r_count;
    logic [LW-1:0] r_len;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_mem [DEPTH];

    logic w_err;
    logic w_term;
    logic w_full;
    logic w_last;
    logic w_wr_en;

    assign w_err   = recv_error & DROP_ON_ERROR;
    assign w_term  = received && (rx_byte == TERMINATOR);
    assign w_full  = (r_count == LW'(DEPTH));
    assign w_last  = ({1'b0, r_rd_ptr} == (r_len - LW'(1)));
    assign w_wr_en = (r_state == S_COLLECT) && received && !w_err
                     && (rx_byte != TERMINATOR) && !w_full;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_err)
                    w_next_state = S_DISCARD;
                else if (w_term && (r_count != '0))
                    w_next_state = S_READY;
            end
            S_DISCARD: if (w_term) w_next_state = S_COLLECT;
            S_READY:   if (rd_en && w_last) w_next_state = S_COLLECT;
            default:   w_next_state = S_COLLECT;
        endcase
    end

    always_comb begin
        line_valid = (r_state == S_READY);
        line_len   = line_valid ? r_len : '0;
        rd_data    = line_valid ? r_mem[r_rd_ptr] : 8'h00;
        // A byte is lost when a line is held, or when a full line gets a non-terminator.
        overflow   = received && ((r_state == S_READY) ||
                     ((r_state == S_COLLECT) && !w_err && (rx_byte != TERMINATOR) && w_full));
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_len    <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en)
                r_count <= r_count + LW'(1);
            else if (w_next_state != r_state)
                r_count <= '0;
            if ((r_state == S_COLLECT) && (w_next_state == S_READY))
                r_len <= r_count;
            if ((r_state == S_READY) && rd_en)
                r_rd_ptr <= w_last ? '0 : r_rd_ptr + PW'(1);
        end
    end

    // Line storage carries no reset; visibility is gated by the state.
    always_ff @(posedge CLK) begin
        if (w_wr_en)
            r_mem[r_count[PW-1:0]] <= rx_byte;
    end
endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Bench for uart_rx_line_buffer: directed line scenarios plus random traffic,
// every cycle compared against a queue-based model of the line buffer.
module tb_uart_rx_line_buffer;
    localparam int         DEPTH = 16;
    localparam logic [7:0] TERM  = 8'h0D;
    localparam int         LW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          received;
    logic [7:0]    rx_byte;
    logic          recv_error;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          line_valid;
    logic [LW-1:0] line_len;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_part[$];
    logic [7:0] m_held[$];
    int         m_rd_idx;
    bit         m_disc;

    logic [7:0] got[$];
    int         ovf_cnt;

    uart_rx_line_buffer #(.DEPTH(DEPTH), .TERMINATOR(TERM), .DROP_ON_ERROR(1'b1)) dut (
        .CLK(CLK), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .rd_en(rd_en), .rd_data(rd_data),
        .line_valid(line_valid), .line_len(line_len), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_part.delete();
        m_held.delete();
        m_rd_idx = 0;
        m_disc   = 1'b0;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model, return at posedge+1.
    task automatic cycle(input bit rcv, input logic [7:0] b, input bit err, input bit rd);
        bit lv;
        bit exp_ovf;
        received = rcv; rx_byte = b; recv_error = err; rd_en = rd;
        @(negedge CLK);
        lv = (m_held.size() != 0);
        exp_ovf = rcv && (lv || (!m_disc && !err && b != TERM && m_part.size() == DEPTH));
        check("line_valid", line_valid, lv);
        check("line_len", line_len, lv ? m_held.size() : 0);
        check("rd_data", rd_data, lv ? m_held[m_rd_idx] : 8'h00);
        check("overflow", overflow, exp_ovf);
        if (overflow) ovf_cnt++;
        if (lv && rd) got.push_back(rd_data);
        if (lv) begin
            if (rd) begin
                m_rd_idx++;
                if (m_rd_idx == m_held.size()) begin
                    m_held.delete();
                    m_rd_idx = 0;
                end
            end
        end else if (m_disc) begin
            if (rcv && b == TERM) begin
                m_disc = 1'b0;
                m_part.delete();
            end
        end else if (err) begin
            m_part.delete();
            m_disc = 1'b1;
        end else if (rcv) begin
            if (b == TERM) begin
                if (m_part.size() > 0) begin
                    m_held   = m_part;
                    m_rd_idx = 0;
                end
                m_part.delete();
            end else if (m_part.size() < DEPTH) begin
                m_part.push_back(b);
            end
        end
        @(posedge CLK);
        #1;
        received = 1'b0; recv_error = 1'b0; rd_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget = 40;
        while (line_valid && budget > 0) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            budget--;
        end
        check("drain_timeout", (budget > 0), 1);
    endtask

    initial begin
        received = 0; rx_byte = 0; recv_error = 0; rd_en = 0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check("rst_line_valid", line_valid, 0);
        check("rst_line_len", line_len, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        #10 rst_n = 1'b1;
        @(posedge CLK); #1;

        // "abc" + terminator
        got.delete();
        send("a"); send("b"); send("c"); send(TERM);
        check("t1_len", line_len, 3);
        drain();
        check("t1_n", got.size(), 3);
        if (got.size() == 3) begin
            check("t1_d0", got[0], 8'h61);
            check("t1_d1", got[1], 8'h62);
            check("t1_d2", got[2], 8'h63);
        end
        check("t1_valid_after", line_valid, 0);

        // bare terminator produces nothing
        send(TERM);
        check("t2_empty", line_valid, 0);
        send("x"); send(TERM);
        check("t2_len", line_len, 1);
        check("t2_data", rd_data, 8'h78);
        got.delete();
        drain();

        // overflow at DEPTH
        ovf_cnt = 0; got.delete();
        for (int i = 0; i < 18; i++) send(8'h41 + 8'(i));
        send(TERM);
        check("t3_ovf", ovf_cnt, 2);
        check("t3_len", line_len, 16);
        drain();
        check("t3_n", got.size(), 16);
        if (got.size() == 16) check("t3_last", got[15], 8'h50);

        // error discards up to the next terminator
        got.delete();
        send("a"); send("b");
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        send("c"); send("d"); send(TERM);
        check("t4_disc", line_valid, 0);
        send("e"); send("f"); send(TERM);
        check("t4_len", line_len, 2);
        drain();
        check("t4_n", got.size(), 2);
        if (got.size() == 2) begin
            check("t4_d0", got[0], 8'h65);
            check("t4_d1", got[1], 8'h66);
        end

        // byte arriving while a line is held
        ovf_cnt = 0; got.delete();
        send("h"); send("i"); send(TERM);
        send("z");
        check("t5_ovf", ovf_cnt, 1);
        drain();
        check("t5_n", got.size(), 2);
        if (got.size() == 2) begin
            check("t5_d0", got[0], 8'h68);
            check("t5_d1", got[1], 8'h69);
        end

        // asynchronous reset while a line is held
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        send(TERM);
        check("t6_len_pre", line_len, 5);
        rst_n = 1'b0;
        #1;
        check("t6_valid", line_valid, 0);
        check("t6_len", line_len, 0);
        check("t6_data", rd_data, 0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge CLK); #1;
        send("q"); send(TERM);
        check("t6_len_post", line_len, 1);
        drain();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit         rcv;
            bit         err;
            bit         rd;
            logic [7:0] b;
            rcv = ($urandom_range(0, 99) < 45);
            err = ($urandom_range(0, 99) < 3);
            rd  = ($urandom_range(0, 99) < 50);
            b   = ($urandom_range(0, 99) < 12) ? TERM : 8'($urandom_range(0, 255));
            cycle(rcv, b, err, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
